// File: rtl/inst_fetch_queue.sv
// Instruction queue between the fetch front end and ID.
// FWFT circular buffer that reserves a slot per outstanding request and discards stale responses after a flush.
module inst_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     req_fire,
  output logic                     req_ok,
  input  logic                     rsp_valid,
  input  logic [PC_W-1:0]          rsp_pc,
  input  logic [31:0]              rsp_ins,
  input  logic                     rsp_exc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PC_W-1:0]          out_pc,
  output logic [31:0]              out_ins,
  output logic                     out_exc,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = PC_W + 33;
  localparam logic [CW:0] LIMIT = (CW+1)'(DEPTH);

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] outstanding_nxt;
  logic [CW-1:0] drop_cnt;
  logic [CW:0]   reserved;
  logic [EW-1:0] head;
  logic          push;
  logic          pop;
  logic          dropping;
  logic          nonempty;

  assign nonempty        = (cnt_q != '0);
  assign dropping        = rsp_valid & (drop_cnt != '0);
  assign push            = rsp_valid & (drop_cnt == '0) & ~flush;
  assign out_valid       = nonempty & ~flush;
  assign pop             = out_valid & out_ready;
  assign outstanding_nxt = outstanding + CW'(req_fire) - CW'(rsp_valid);

  // Every queued entry and every in-flight request holds a slot, so a response can never overflow.
  assign reserved = {1'b0, cnt_q} + {1'b0, outstanding};
  assign req_ok   = (reserved < LIMIT);

  assign head    = mem[rd_ptr];
  assign out_pc  = nonempty ? head[PC_W-1:0]     : '0;
  assign out_ins = nonempty ? head[PC_W+31:PC_W] : '0;
  assign out_exc = nonempty ? head[EW-1]         : 1'b0;
  assign count   = cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      cnt_q       <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (flush) begin
        // Everything requested up to and including this cycle is now stale.
        cnt_q    <= '0;
        rd_ptr   <= wr_ptr;
        drop_cnt <= outstanding_nxt;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        if (push && !pop)      cnt_q <= cnt_q + 1'b1;
        else if (pop && !push) cnt_q <= cnt_q - 1'b1;
        if (dropping) drop_cnt <= drop_cnt - 1'b1;
      end
    end
  end

  // Storage needs no reset; out_* are gated by the occupancy count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {rsp_exc, rsp_ins, rsp_pc};
  end

endmodule
